// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and defaults for the sync_fifo write arbiter.
package sync_fifo_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, BUSY holds one producer's grant for a packet.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MAX_BURST  = 16;

  // Beat counter width: enough to count 0..MAX_BURST-1, never narrower than 1 bit.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is doubled so the
// search can start at any pointer and run NUM_REQ positions without an
// explicit wrap test inside the priority chain.
module rr_pick
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  localparam int DBL_W = $clog2(2 * NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [DBL_W-1:0]     sel;
  logic [DBL_W-1:0]     wrap;
  logic                 found;

  assign req_dbl = {req, req};

  // First set request at or after ptr, folded back into 0..NUM_REQ-1.
  always_comb begin
    found      = 1'b0;
    sel        = '0;
    wrap       = '0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel = DBL_W'(ptr) + DBL_W'(i);
      if (!found && req_dbl[sel]) begin
        found = 1'b1;
        wrap  = (sel >= DBL_W'(NUM_REQ)) ? (sel - DBL_W'(NUM_REQ)) : sel;
        gnt_idx    = IDX_W'(wrap);
        gnt_onehot = NUM_REQ'(1) << wrap;
      end
    end
    any = found;
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Packet-aware round-robin write arbiter in front of one sync_fifo.
// Handshake: a beat moves from the granted producer into the FIFO in any
// cycle where o_valid_s and i_ready_s are both 1; o_req_ready of the granted
// producer is exactly i_ready_s (combinational), so producer and FIFO see the
// same transfer in the same cycle. Valid must not wait on ready.
// o_busy is the FSM state bit (1 = BUSY) and doubles as the state debug view.
module sync_fifo_wr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST,
  parameter int REQ_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_valid_s,
  output logic [DATA_WIDTH-1:0]         o_datain,
  input  logic                          i_ready_s,
  input  logic                          i_almostfull,
  output logic [REQ_WIDTH-1:0]          o_gnt_idx,
  output logic                          o_busy
);

  localparam int                   CNT_W    = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [REQ_WIDTH-1:0] IDX_LAST = REQ_WIDTH'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [REQ_WIDTH-1:0] rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [REQ_WIDTH-1:0] pick_idx;
  logic                 pick_any;

  logic                 gnt_valid;
  logic                 gnt_last;
  logic                 xfer;
  logic                 release_now;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_WIDTH)
  ) u_rr_pick (
    .req        (i_req_valid),
    .ptr        (rr_q),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // Valid/last of the held grant; the one-hot copy avoids a second index mux.
  assign gnt_valid = |(i_req_valid & gnt_oh_q);
  assign gnt_last  = |(i_req_last & gnt_oh_q);

  assign xfer        = (state_q == BUSY) && gnt_valid && i_ready_s;
  // Last beat and burst limit may coincide; either ends the grant once.
  assign release_now = xfer && (gnt_last || (cnt_q == CNT_LAST));

  // Next-state and handshake outputs; almost-full only gates new grants.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_oh_d    = gnt_oh_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    o_valid_s   = 1'b0;
    o_req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_any && !i_almostfull) begin
          state_d  = BUSY;
          gnt_d    = pick_idx;
          gnt_oh_d = pick_oh;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        o_valid_s   = gnt_valid;
        o_req_ready = gnt_oh_q & {NUM_REQ{i_ready_s}};
        if (release_now) begin
          state_d = IDLE;
          rr_d    = (gnt_q == IDX_LAST) ? '0 : (gnt_q + 1'b1);
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write data follows gnt_idx at all times so it is never X after reset.
  always_comb begin
    o_datain = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q == REQ_WIDTH'(k)) begin
        o_datain = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_gnt_idx = gnt_q;
  assign o_busy    = (state_q == BUSY);

endmodule

// File: doc/sync_fifo_wr_arbiter.md
# sync_fifo_wr_arbiter

Packet-aware round-robin write arbiter that shares the write port of one `sync_fifo` among `NUM_REQ` independent producers. Each producer presents valid/data/last beats. The arbiter grants one producer at a time and holds that grant for a whole packet, bounded by `MAX_BURST` beats. It stops starting new packets while the FIFO reports almost-full. The block sits directly in front of `sync_fifo`: its outputs drive `i_valid_s`/`i_datain`, and it consumes `o_ready_s`/`o_almostfull`.

## Interface
- `NUM_REQ`, 4: number of producers, 2..16.
- `DATA_WIDTH`, `` `DATA_WIDTH ``: beat width, matches the FIFO.
- `MAX_BURST`, 16: maximum beats per grant, ≥1.
- `REQ_WIDTH`, `$clog2(NUM_REQ)`: grant index width.
- `i_clk` in 1: clock. The block uses one clock; reset is synchronous and active-high.
- `i_rst` in 1: synchronous active-high reset.
- `i_req_valid` in `NUM_REQ`: per-producer beat valid.
- `i_req_data` in `NUM_REQ*DATA_WIDTH`: producer k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `i_req_last` in `NUM_REQ`: last beat of the producer's packet.
- `o_req_ready` out `NUM_REQ`: per-producer beat accepted.
- `o_valid_s` out 1: write request, drives FIFO `i_valid_s`.
- `o_datain` out `DATA_WIDTH`: write data, drives FIFO `i_datain`.
- `i_ready_s` in 1: FIFO `o_ready_s`, meaning not full.
- `i_almostfull` in 1: FIFO `o_almostfull`.
- `o_gnt_idx` out `REQ_WIDTH`: index of the current or last grant.
- `o_busy` out 1: a grant is held (state `BUSY`).

## Operation
- FSM states: `IDLE`, `BUSY`.
- In `IDLE`:
  - `o_valid_s` = 0 and `o_req_ready` = 0.
  - If any `i_req_valid` is set and `i_almostfull` = 0, select the winner by round-robin, starting the search at `rr_ptr`.
  - Register the winner into `gnt_idx`, clear `beat_cnt`, and move to `BUSY`.
- In `BUSY`:
  - `o_valid_s` = `i_req_valid[gnt_idx]`.
  - `o_datain` = the slice of `gnt_idx`.
  - `o_req_ready[gnt_idx]` = `i_ready_s`; all other ready bits are 0.
  - A transfer occurs when `o_valid_s` and `i_ready_s` are both 1. Each transfer increments `beat_cnt`.
  - On a transfer with `i_req_last[gnt_idx]` = 1, or with `beat_cnt` = `MAX_BURST-1`: go to `IDLE` and set `rr_ptr` = `gnt_idx+1` (mod `NUM_REQ`).
- Almost-full only blocks new grants. A packet already in progress continues; full back-pressure comes through `i_ready_s`.
- A granted producer that drops valid mid-packet stalls the grant. There is no timeout and no reassignment.
- `o_datain` is a combinational mux. When `o_valid_s` = 0 its value is don't-care but must not be X after reset; drive the slice at `gnt_idx`.
- Reset mid-packet: the packet is abandoned. The FSM returns to `IDLE` with no partial flush.

## Timing
- All registers clear on `i_rst`: state = `IDLE`, `gnt_idx` = 0, `rr_ptr` = 0, `beat_cnt` = 0.
- Output values in reset: `o_valid_s` = 0, `o_req_ready` = 0, `o_gnt_idx` = 0, `o_busy` = 0.
- Arbitration latency is 1 cycle. A valid seen in `IDLE` at edge N grants at edge N+1, and the first beat can transfer in cycle N+1.
- Throughput in `BUSY` is 1 beat per cycle while valid and ready are both high.
- Each packet costs 1 idle cycle of arbitration overhead.
- Ready to data path is purely combinational: `o_req_ready` depends on `i_ready_s` in the same cycle, with no registers in the path.
- `o_busy` and `o_gnt_idx` are registered outputs.
- `beat_cnt` width is `$clog2(MAX_BURST)` with a minimum of 1. It never wraps, because the FSM leaves `BUSY` at `MAX_BURST-1`.
- Round-robin: `rr_ptr` wraps from `NUM_REQ-1` to 0. A lone requester is re-granted every packet, with 1 idle cycle between packets.
- Simultaneous `last` and `MAX_BURST` limit: a single release, with one pointer update.

## Structure
- Package `sync_fifo_arb_pkg` holds the FSM enum `arb_state_t` (`IDLE`, `BUSY`) and the default `MAX_BURST` constant.
- Sub-module `rr_pick`, combinational, parameterised by `NUM_REQ`.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot winner, binary index, and `any`.
  - Implementation: a doubled-vector priority search.

## Test plan
- Single producer, with reset released: producer 2 sends a 3-beat packet (`0xA1`, `0xA2`, `0xA3` with last). Required: FIFO receives these three beats in order, `o_gnt_idx` = 2, `o_busy` high for exactly 3 cycles, then `IDLE` for 1 cycle.
- Fairness: all 4 producers hold valid continuously with 1-beat packets. Required: grant order 0, 1, 2, 3, 0, …, and each producer gets 25% of beats over 40 packets.
- Burst limit: `MAX_BURST` = 16; producer 0 sends a 20-beat packet while producer 1 is waiting. Required: 16 beats from producer 0, then producer 1's packet, then the remaining 4 beats of producer 0.
- Back-pressure:
  - Force `i_ready_s` = 0 for 5 cycles mid-packet. Required: no beats lost or duplicated; `o_req_ready` = 0 throughout.
  - Raise `i_almostfull` in `IDLE`. Required: no new grant until it falls.
- Reset mid-packet: assert `i_rst` on beat 2 of 4. Required: next cycle all outputs are at their reset values, and producer 0 is granted first afterwards.
- Random: random valid/last/ready for 2000 cycles against a scoreboard. Required: per-producer beat order is preserved and packets never interleave at the FIFO input.
